// File: rtl/cva6_decerr_slave_pkg.sv
// ============================================================================
// Module      : cva6_decerr_slave_pkg
// Description : Shared widths, response codes, error pattern and FSM state
//               types for the CVA6 default-port DECERR slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cva6_decerr_slave_pkg;

    localparam int unsigned c_ID_WIDTH   = 3;
    localparam int unsigned c_ADDR_WIDTH = 64;
    localparam int unsigned c_DATA_WIDTH = 64;

    // AXI response code for "no slave at this address"
    localparam logic [1:0]  c_RESP_DECERR      = 2'b11;
    // Recognisable filler returned on every read beat
    localparam logic [63:0] c_ERR_DATA_PATTERN = 64'hBADC_AB1E_BADC_AB1E;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/cva6_decerr_slave_if.sv
// ============================================================================
// Module      : cva6_decerr_slave_if
// Description : AXI4 subset seen by the DECERR slave (AW, W, B, AR, R).
//               Signal suffixes are written from the slave's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cva6_decerr_slave_if
    import cva6_decerr_slave_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = c_ID_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH
);
    logic                  aw_valid_i;
    logic                  aw_ready_o;
    logic [ID_WIDTH-1:0]   aw_id_i;
    logic [ADDR_WIDTH-1:0] aw_addr_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic                  w_last_i;
    logic                  b_valid_o;
    logic                  b_ready_i;
    logic [ID_WIDTH-1:0]   b_id_o;
    logic [1:0]            b_resp_o;
    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [ID_WIDTH-1:0]   ar_id_i;
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic [7:0]            ar_len_i;
    logic                  r_valid_o;
    logic                  r_ready_i;
    logic [ID_WIDTH-1:0]   r_id_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_last_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
               ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
               ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );

    modport master (
        output aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
               ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
               ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );

endinterface

`default_nettype wire

// File: rtl/cva6_decerr_slave_rd_gen.sv
// ============================================================================
// Module      : cva6_decerr_rd_gen
// Description : Read side of the DECERR slave. Accepts one AR at a time and
//               returns len+1 beats, flagging the final one with r_last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cva6_decerr_rd_gen
    import cva6_decerr_slave_pkg::*;
#(
    parameter int unsigned ID_WIDTH = c_ID_WIDTH
) (
    input  wire logic                clk_i,
    input  wire logic                rst_i,
    input  wire logic                ar_valid_i,
    output logic                     ar_ready_o,
    input  wire logic [ID_WIDTH-1:0] ar_id_i,
    input  wire logic [7:0]          ar_len_i,
    output logic                     r_valid_o,
    input  wire logic                r_ready_i,
    output logic [ID_WIDTH-1:0]      r_id_o,
    output logic                     r_last_o,
    output logic                     ar_hs_o
);

    rd_state_e           state_q;
    logic                ar_ready_q;
    logic                r_valid_q;
    logic                r_last_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic                ar_hs;
    logic                r_hs;

    assign ar_hs = ar_valid_i && ar_ready_q;
    assign r_hs  = r_valid_q && r_ready_i;
    // Counter only advances on non-final beats, so len=255 tops out at 255
    assign cnt_d = cnt_q + 8'd1;

    // Read FSM: registered handshake outputs, beat counter and last flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            id_q       <= '0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        state_q    <= R_DATA;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        id_q       <= ar_id_i;
                        len_q      <= ar_len_i;
                        cnt_q      <= 8'd0;
                        r_last_q   <= (ar_len_i == 8'd0);
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (r_last_q) begin
                            state_q    <= R_IDLE;
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            ar_ready_q <= 1'b1;
                        end else begin
                            cnt_q    <= cnt_d;
                            r_last_q <= (cnt_d == len_q);
                        end
                    end
                end
                default: begin
                    state_q    <= R_IDLE;
                    ar_ready_q <= 1'b1;
                    r_valid_q  <= 1'b0;
                    r_last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_id_o     = id_q;
    assign r_last_o   = r_last_q;
    assign ar_hs_o    = ar_hs;

endmodule

`default_nettype wire

// File: rtl/cva6_decerr_slave.sv
// ============================================================================
// Module      : cva6_decerr_slave
// Description : AXI4 default-port slave. Drains writes and answers DECERR,
//               returns DECERR read beats, and logs the first offending
//               address. Optional macro CVA6_DECERR_COUNTER_EN adds a
//               saturating err_cnt_o of accepted AW+AR handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cva6_decerr_slave
    import cva6_decerr_slave_pkg::*;
#(
    parameter int unsigned          ID_WIDTH   = c_ID_WIDTH,
    parameter int unsigned          ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int unsigned          DATA_WIDTH = c_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA  = DATA_WIDTH'(c_ERR_DATA_PATTERN)
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    cva6_decerr_slave_if.slave      bus,
    output logic                    err_valid_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic                    err_is_wr_o,
`ifdef CVA6_DECERR_COUNTER_EN
    output logic [15:0]             err_cnt_o,
`endif
    input  wire logic               err_clr_i
);

    wr_state_e             wstate_q;
    logic                  aw_ready_q;
    logic                  w_ready_q;
    logic                  b_valid_q;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic                  aw_hs;
    logic                  ar_hs;
    logic                  log_en;
    logic                  err_valid_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic                  err_is_wr_q;

    assign aw_hs = bus.aw_valid_i && aw_ready_q;

    // Write FSM: accept AW, swallow W beats up to w_last, then hold B
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate_q   <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        wstate_q   <= W_DATA;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        b_id_q     <= bus.aw_id_i;
                    end
                end
                W_DATA: begin
                    if (bus.w_valid_i && w_ready_q && bus.w_last_i) begin
                        wstate_q  <= W_RESP;
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bus.b_ready_i) begin
                        wstate_q   <= W_IDLE;
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                    end
                end
                default: begin
                    wstate_q   <= W_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b0;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    cva6_decerr_rd_gen #(
        .ID_WIDTH (ID_WIDTH)
    ) u_rd_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_valid_i (bus.ar_valid_i),
        .ar_ready_o (bus.ar_ready_o),
        .ar_id_i    (bus.ar_id_i),
        .ar_len_i   (bus.ar_len_i),
        .r_valid_o  (bus.r_valid_o),
        .r_ready_i  (bus.r_ready_i),
        .r_id_o     (bus.r_id_o),
        .r_last_o   (bus.r_last_o),
        .ar_hs_o    (ar_hs)
    );

    // A clear in the same cycle frees the log slot, so the new capture wins
    assign log_en = (aw_hs || ar_hs) && (!err_valid_q || err_clr_i);

    // Error log: first offending address and direction, AW preferred over AR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_is_wr_q <= 1'b0;
        end else if (log_en) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= aw_hs ? bus.aw_addr_i : bus.ar_addr_i;
            err_is_wr_q <= aw_hs;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

`ifdef CVA6_DECERR_COUNTER_EN
    logic [15:0] cnt_q;
    logic [1:0]  inc_d;
    logic [16:0] sum_d;

    assign inc_d = {1'b0, aw_hs} + {1'b0, ar_hs};
    assign sum_d = {1'b0, cnt_q} + {15'd0, inc_d};

    // Saturating handshake counter; clear restarts from this cycle's increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else if (err_clr_i) begin
            cnt_q <= {14'd0, inc_d};
        end else begin
            cnt_q <= sum_d[16] ? 16'hFFFF : sum_d[15:0];
        end
    end

    assign err_cnt_o = cnt_q;
`endif

    assign bus.aw_ready_o = aw_ready_q;
    assign bus.w_ready_o  = w_ready_q;
    assign bus.b_valid_o  = b_valid_q;
    assign bus.b_id_o     = b_id_q;
    assign bus.b_resp_o   = c_RESP_DECERR;
    assign bus.r_data_o   = ERR_DATA;
    assign bus.r_resp_o   = c_RESP_DECERR;

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_is_wr_o = err_is_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_cva6_decerr_slave.sv
// ============================================================================
// Module      : tb_cva6_decerr_slave
// Description : Directed + randomized bench for cva6_decerr_slave with a
//               transaction-level model of the error log and counter.
//               Honours CVA6_DECERR_COUNTER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cva6_decerr_slave;
    import cva6_decerr_slave_pkg::*;

    localparam logic [63:0] c_EXP_DATA = 64'hBADC_AB1E_BADC_AB1E;

    logic        clk;
    logic        rst;
    logic        err_clr;
    logic        err_valid;
    logic [63:0] err_addr;
    logic        err_is_wr;
`ifdef CVA6_DECERR_COUNTER_EN
    logic [15:0] err_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the log / counter state
    logic        m_vld;
    logic [63:0] m_addr;
    logic        m_wr;
    int          m_cnt;

    cva6_decerr_slave_if bus ();

    cva6_decerr_slave dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .err_valid_o (err_valid),
        .err_addr_o  (err_addr),
        .err_is_wr_o (err_is_wr),
`ifdef CVA6_DECERR_COUNTER_EN
        .err_cnt_o   (err_cnt),
`endif
        .err_clr_i   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Model of one clock edge: who gets logged and how far the count moves
    task automatic log_event(input bit aw, input bit ar, input logic [63:0] aw_a,
                             input logic [63:0] ar_a, input bit clr);
        int inc;
        inc = int'(aw) + int'(ar);
        if ((aw || ar) && (!m_vld || clr)) begin
            m_vld  = 1'b1;
            m_addr = aw ? aw_a : ar_a;
            m_wr   = aw;
        end else if (clr) begin
            m_vld = 1'b0;
        end
        if (clr) m_cnt = inc;
        else     m_cnt = (m_cnt + inc > 65535) ? 65535 : m_cnt + inc;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_err_valid"}, err_valid, m_vld);
        chk({tag, "_err_addr"},  err_addr,  m_addr);
        chk({tag, "_err_is_wr"}, err_is_wr, m_wr);
`ifdef CVA6_DECERR_COUNTER_EN
        chk({tag, "_err_cnt"},   err_cnt,   m_cnt[15:0]);
`endif
    endtask

    task automatic aw_phase(input logic [2:0] id, input logic [63:0] addr);
        int guard = 0;
        bus.aw_valid_i = 1'b1; bus.aw_id_i = id; bus.aw_addr_i = addr;
        while (!bus.aw_ready_o && guard < 20) begin @(negedge clk); guard++; end
        chk("aw_ready", bus.aw_ready_o, 1'b1);
        log_event(1'b1, 1'b0, addr, 64'd0, 1'b0);
        @(negedge clk);
        bus.aw_valid_i = 1'b0;
        chk_log("aw");
    endtask

    task automatic w_phase(input int beats);
        int n = 0;
        int guard = 0;
        bit v;
        while (n < beats && guard < 1000) begin
            chk("w_ready", bus.w_ready_o, 1'b1);
            chk("b_valid_early", bus.b_valid_o, 1'b0);
            v = ($urandom_range(0, 3) != 0);
            bus.w_valid_i = v;
            bus.w_last_i  = v && (n == beats - 1);
            if (v) n++;
            @(negedge clk); guard++;
        end
        bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
        chk("w_guard", n, beats);
    endtask

    task automatic b_phase(input logic [2:0] id);
        int d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
            chk("b_hold_valid", bus.b_valid_o, 1'b1);
            chk("b_hold_awready", bus.aw_ready_o, 1'b0);
            @(negedge clk);
        end
        chk("b_valid", bus.b_valid_o, 1'b1);
        chk("b_id", bus.b_id_o, id);
        chk("b_resp", bus.b_resp_o, 2'b11);
        chk("w_ready_resp", bus.w_ready_o, 1'b0);
        bus.b_ready_i = 1'b1;
        @(negedge clk);
        bus.b_ready_i = 1'b0;
        chk("b_done", bus.b_valid_o, 1'b0);
        chk("aw_ready_back", bus.aw_ready_o, 1'b1);
    endtask

    task automatic ar_phase(input logic [2:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input bit clr);
        int guard = 0;
        bus.ar_valid_i = 1'b1; bus.ar_id_i = id; bus.ar_addr_i = addr; bus.ar_len_i = len;
        err_clr = clr;
        while (!bus.ar_ready_o && guard < 20) begin @(negedge clk); guard++; end
        chk("ar_ready", bus.ar_ready_o, 1'b1);
        log_event(1'b0, 1'b1, 64'd0, addr, clr);
        @(negedge clk);
        bus.ar_valid_i = 1'b0; err_clr = 1'b0;
        chk_log("ar");
    endtask

    task automatic r_phase(input logic [2:0] id, input int len, input bit bp);
        int n = 0;
        int guard = 0;
        bit rr;
        while (n <= len && guard < 5000) begin
            chk("r_valid", bus.r_valid_o, 1'b1);
            chk("r_last", bus.r_last_o, (n == len));
            chk("r_id", bus.r_id_o, id);
            chk("r_data", bus.r_data_o, c_EXP_DATA);
            chk("r_resp", bus.r_resp_o, 2'b11);
            chk("ar_ready_busy", bus.ar_ready_o, 1'b0);
            rr = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.r_ready_i = rr;
            if (rr) n++;
            @(negedge clk); guard++;
        end
        bus.r_ready_i = 1'b0;
        chk("r_beats", n, len + 1);
        chk("r_done", bus.r_valid_o, 1'b0);
        chk("ar_ready_back", bus.ar_ready_o, 1'b1);
    endtask

    initial begin
        logic [2:0]  rid;
        logic [63:0] raddr;
        int          rlen;

        rst = 1'b1; err_clr = 1'b0;
        bus.aw_valid_i = 1'b0; bus.aw_id_i = '0; bus.aw_addr_i = '0;
        bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0; bus.b_ready_i = 1'b0;
        bus.ar_valid_i = 1'b0; bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0;
        bus.r_ready_i = 1'b0;
        m_vld = 1'b0; m_addr = '0; m_wr = 1'b0; m_cnt = 0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_aw_ready", bus.aw_ready_o, 1'b1);
        chk("rst_ar_ready", bus.ar_ready_o, 1'b1);
        chk("rst_w_ready", bus.w_ready_o, 1'b0);
        chk("rst_b_valid", bus.b_valid_o, 1'b0);
        chk("rst_r_valid", bus.r_valid_o, 1'b0);
        chk_log("rst");
        rst = 1'b0;
        @(negedge clk);

        // W before AW is stalled
        bus.w_valid_i = 1'b1;
        @(negedge clk);
        chk("w_stall", bus.w_ready_o, 1'b0);
        bus.w_valid_i = 1'b0;

        // Plan 1: write burst, id 5, four beats
        aw_phase(3'd5, 64'h8000_0000);
        w_phase(4);
        b_phase(3'd5);
        chk("p1_err_addr", err_addr, 64'h8000_0000);
        chk("p1_err_wr", err_is_wr, 1'b1);

        // Plan 2 and 3: short read with back-pressure, then 256-beat burst
        ar_phase(3'd2, 64'h1000, 8'd3, 1'b0);
        r_phase(3'd2, 3, 1'b1);
        ar_phase(3'd6, 64'h2000, 8'd255, 1'b0);
        r_phase(3'd6, 255, 1'b1);

        // Plan 4: clear log, then simultaneous AW/AR
        err_clr = 1'b1;
        log_event(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
        @(negedge clk);
        err_clr = 1'b0;
        chk_log("clr");
        bus.aw_valid_i = 1'b1; bus.aw_id_i = 3'd1; bus.aw_addr_i = 64'h1;
        bus.ar_valid_i = 1'b1; bus.ar_id_i = 3'd3; bus.ar_addr_i = 64'h2; bus.ar_len_i = 8'd1;
        chk("sim_aw_ready", bus.aw_ready_o, 1'b1);
        chk("sim_ar_ready", bus.ar_ready_o, 1'b1);
        log_event(1'b1, 1'b1, 64'h1, 64'h2, 1'b0);
        @(negedge clk);
        bus.aw_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
        chk_log("sim");
        w_phase(2);
        b_phase(3'd1);
        r_phase(3'd3, 1, 1'b1);
        chk("p4_addr", err_addr, 64'h1);
        chk("p4_wr", err_is_wr, 1'b1);
        ar_phase(3'd0, 64'h3, 8'd0, 1'b0);
        r_phase(3'd0, 0, 1'b0);
        chk("p4_not_logged", err_addr, 64'h1);

        // Plan 5: clear coincident with a new AR capture
        ar_phase(3'd4, 64'h4, 8'd1, 1'b1);
        chk("p5_valid", err_valid, 1'b1);
        chk("p5_addr", err_addr, 64'h4);
        r_phase(3'd4, 1, 1'b0);

        // Randomized traffic with occasional clears
        for (int t = 0; t < 8; t++) begin
            rid   = 3'($urandom_range(0, 7));
            raddr = {32'($urandom), 32'($urandom)};
            rlen  = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                aw_phase(rid, raddr);
                w_phase(rlen + 1);
                b_phase(rid);
            end else begin
                ar_phase(rid, raddr, 8'(rlen), ($urandom_range(0, 2) == 0));
                r_phase(rid, rlen, 1'b1);
            end
            chk_log("rand");
        end

        // Plan 6: reset in the middle of an 8-beat read
        ar_phase(3'd7, 64'h40, 8'd7, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("p6_beat", bus.r_valid_o, 1'b1);
            bus.r_ready_i = 1'b1;
            @(negedge clk);
        end
        bus.r_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("p6_r_valid_async", bus.r_valid_o, 1'b0);
        m_vld = 1'b0; m_addr = '0; m_wr = 1'b0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("p6_ar_ready", bus.ar_ready_o, 1'b1);
        chk("p6_r_valid", bus.r_valid_o, 1'b0);
        chk_log("p6");
        ar_phase(3'd2, 64'h50, 8'd2, 1'b0);
        r_phase(3'd2, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cva6_decerr_slave.md
Name: cva6_decerr_slave

Overview:
- AXI4 slave attached to the crossbar default (unmapped) port of the CVA6 wrapper SoC bus.
- Any access outside the Debug, CLINT, PLIC and External regions lands here.
- Write bursts are drained and answered with DECERR; read bursts return len+1 DECERR beats.
- The first offending address is logged for software/debug diagnosis.

Parameters:
- IdWidth, 3, AXI ID width on the crossbar slave side (AxiIdWidthSlaves).
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width.
- ErrData, 64'hBADC_AB1E_BADC_AB1E, constant returned on r_data_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write address
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  response ID
- b_resp_o  out  2  response code, always 2'b11
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read address
- ar_len_i  in  8  burst length minus 1
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  IdWidth  read ID
- r_data_o  out  DataWidth  ErrData
- r_resp_o  out  2  always 2'b11
- r_last_o  out  1  last read beat
- err_valid_o  out  1  sticky "error address logged"
- err_addr_o  out  AddrWidth  first logged offending address
- err_is_wr_o  out  1  logged error was a write
- err_clr_i  in  1  clears err_valid_o

Behaviour:
- Reset state:
  - All *_valid_o outputs = 0; aw_ready_o = ar_ready_o = 1; w_ready_o = 0.
  - err_valid_o = 0; err_addr_o = 0; err_is_wr_o = 0.
  - Both FSMs enter IDLE; the beat counter is 0.
- Reset mid-burst aborts immediately. No B/R is emitted for the aborted transaction.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready_o = 1. On an AW handshake, capture aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o = 1. Each W handshake is discarded. A handshake with w_last_i = 1 goes to W_RESP.
  - W_RESP: b_valid_o = 1 and b_id_o = the captured ID. On b_ready_i, return to W_IDLE.
  - b_valid_o rises 1 cycle after the last-W handshake. It holds until b_ready_i, even if further AW arrive; aw_ready_o = 0 outside W_IDLE.
  - W beats presented before AW acceptance are stalled (w_ready_o = 0).
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready_o = 1. On an AR handshake, capture ar_id_i and ar_len_i, clear the counter, and go to R_DATA.
  - R_DATA: r_valid_o = 1. r_last_o = (cnt == len). Each R handshake increments the 8-bit counter. A handshake with r_last_o = 1 returns to R_IDLE.
  - len = 255 produces 256 beats; the counter must not wrap before the last beat.
  - First R beat is valid 1 cycle after the AR handshake. r_data_o/r_resp_o/r_id_o stay stable while r_valid_o && !r_ready_i.
- Read and write FSMs are fully independent and may be active simultaneously.
- Error log:
  - On any AW or AR handshake while err_valid_o = 0, latch the address and direction, and set err_valid_o the next cycle.
  - Simultaneous AW and AR handshakes: AW wins (err_is_wr_o = 1).
  - err_clr_i in the same cycle as a new capture: the capture wins and err_valid_o stays 1 with the new address.
  - While err_valid_o = 1, later errors are not logged.

Optional Feature:
- Macro: CVA6_DECERR_COUNTER_EN.
- When defined, adds output err_cnt_o [15:0]: a saturating count of accepted AW plus AR handshakes.
  - A simultaneous AW and AR handshake counts +2, saturating at 16'hFFFF.
  - err_clr_i zeroes the counter; a same-cycle increment yields 1 or 2.
  - Reset value is 0.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- cva6_wrapper_pkg gains:
  - RESP_DECERR = 2'b11.
  - ErrDataPattern constant.
  - State enums wr_state_e and rd_state_e.
- Widths come from the existing package localparams.
- One natural sub-module: cva6_decerr_rd_gen, containing the read FSM and beat counter. The write FSM and error log stay in the top.

Test Plan:
1. AW id=5 addr=0x8000_0000, then 4 W beats with last on beat 4 -> single B, id=5, resp=2'b11, one cycle after the last W. err_addr_o=0x8000_0000, err_is_wr_o=1.
2. AR id=2 len=3 -> exactly 4 R beats, data=0xBADCAB1EBADCAB1E, resp=2'b11. r_last_o only on beat 4. Random r_ready_i back-pressure must keep all outputs stable.
3. AR len=255 -> 256 beats with r_last_o only on beat 256, then ar_ready_o=1 again.
4. Simultaneous AW addr=0x1 and AR addr=0x2 in the same cycle, err_valid_o=0 -> both channels complete. Log holds 0x1 with err_is_wr_o=1. A later AR 0x3 is not logged.
5. err_clr_i asserted in the same cycle as an AR handshake at 0x4 -> err_valid_o=1 and err_addr_o=0x4.
6. rst_i pulsed mid read burst (after beat 2 of 8) -> r_valid_o=0 immediately, ar_ready_o=1 after release. With CVA6_DECERR_COUNTER_EN defined, err_cnt_o=0.
